// File: rtl/color_sensor_pkg.sv
// Shared encodings for the TCS3200-style colour sensor emulator and the colour detection path.
`timescale 1ns/1ps
package color_sensor_pkg;

   localparam int HP_W  = 16;
   localparam int EFF_W = 22;

   localparam logic [1:0] FILT_RED   = 2'b00;
   localparam logic [1:0] FILT_GREEN = 2'b11;
   localparam logic [1:0] FILT_BLUE  = 2'b01;
   localparam logic [1:0] FILT_CLEAR = 2'b10;

   localparam logic [1:0] SCALE_PDOWN  = 2'b00;
   localparam logic [1:0] SCALE_2PCT   = 2'b01;
   localparam logic [1:0] SCALE_20PCT  = 2'b10;
   localparam logic [1:0] SCALE_100PCT = 2'b11;

   localparam logic [5:0] MULT_2PCT   = 6'd50;
   localparam logic [5:0] MULT_20PCT  = 6'd5;
   localparam logic [5:0] MULT_100PCT = 6'd1;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      RUN    = 2'd1,
      PDOWN  = 2'd2
   } sensorState_e;

   // Output frequency scales down, so the half-period scales up by the inverse factor.
   function automatic logic [EFF_W-1:0] effHalfPeriod(input logic [HP_W-1:0] hp,
                                                      input logic [1:0] scale);
      logic [5:0] mult;
      case (scale)
         SCALE_2PCT:   mult = MULT_2PCT;
         SCALE_20PCT:  mult = MULT_20PCT;
         SCALE_100PCT: mult = MULT_100PCT;
         default:      mult = 6'd0;
      endcase
      return EFF_W'(hp) * EFF_W'(mult);
   endfunction

endpackage

// File: rtl/color_sensor_emulator_wave_gen.sv
// Square-wave generator: phase counter, half-period reload at each toggle, rising-edge counter.
`timescale 1ns/1ps
module cs_wave_gen
   import color_sensor_pkg::*;
(
   input  logic             clk_1MHz,
   input  logic             rst_n,
   input  logic [EFF_W-1:0] i_eff,
   input  logic             i_restart,
   input  logic             i_enable,
   output logic             o_csOut,
   output logic [15:0]      o_edgeCnt
);

   logic [EFF_W-1:0] r_phase;
   logic [EFF_W-1:0] r_effQ;
   logic             r_csOut;
   logic [15:0]      r_edgeCnt;

   // A zero half-period means "no light": keep re-sampling eff until it becomes non-zero.
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_phase   <= '0;
         r_effQ    <= '0;
         r_csOut   <= 1'b0;
         r_edgeCnt <= '0;
      end else if (i_restart) begin
         r_phase   <= '0;
         r_effQ    <= i_eff;
         r_csOut   <= 1'b0;
         r_edgeCnt <= '0;
      end else if (i_enable) begin
         if (r_effQ == '0) begin
            r_effQ <= i_eff;
         end else if (r_phase == r_effQ - EFF_W'(1)) begin
            r_phase <= '0;
            r_effQ  <= i_eff;
            r_csOut <= ~r_csOut;
            if (!r_csOut && (r_edgeCnt != 16'hFFFF)) begin
               r_edgeCnt <= r_edgeCnt + 16'd1;
            end
         end else begin
            r_phase <= r_phase + EFF_W'(1);
         end
      end
   end

   assign o_csOut   = r_csOut;
   assign o_edgeCnt = r_edgeCnt;

endmodule

// File: rtl/color_sensor_emulator.sv
// TCS3200-style colour sensor model: half-period registers, filter/scale change detect and settle FSM.
`timescale 1ns/1ps
module color_sensor_emulator
   import color_sensor_pkg::*;
#(
   parameter int HP_RED     = 100,
   parameter int HP_GREEN   = 80,
   parameter int HP_BLUE    = 120,
   parameter int HP_CLEAR   = 40,
   parameter int SETTLE_CYC = 10
) (
   input  logic        clk_1MHz,
   input  logic        rst_n,
   input  logic [1:0]  filter,
   input  logic [1:0]  scale,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_sel,
   input  logic [15:0] cfg_data,
   output logic        cs_out,
   output logic        settling,
   output logic [15:0] edge_cnt
);

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   logic [HP_W-1:0]  r_hp [4];
   logic [1:0]       r_filtQ;
   logic [1:0]       r_scaleQ;
   sensorState_e     r_state;
   logic [CNT_W-1:0] r_settleCnt;

   sensorState_e     w_nextState;
   logic [CNT_W-1:0] w_settleCntNext;
   logic             w_restart;
   logic             w_change;
   logic [1:0]       w_newScale;
   logic [EFF_W-1:0] w_eff;

   assign w_change   = (filter != r_filtQ) || (scale != r_scaleQ);
   assign w_newScale = w_change ? scale : r_scaleQ;
   assign w_eff      = effHalfPeriod(r_hp[r_filtQ], r_scaleQ);

   // The hp registers and captured selects return to their reset values on any rst_n assertion.
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_hp[FILT_RED]   <= HP_W'(HP_RED);
         r_hp[FILT_GREEN] <= HP_W'(HP_GREEN);
         r_hp[FILT_BLUE]  <= HP_W'(HP_BLUE);
         r_hp[FILT_CLEAR] <= HP_W'(HP_CLEAR);
         r_filtQ          <= filter;
         r_scaleQ         <= scale;
      end else begin
         if (cfg_we) begin
            r_hp[cfg_sel] <= cfg_data;
         end
         if (w_change) begin
            r_filtQ  <= filter;
            r_scaleQ <= scale;
         end
      end
   end

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SETTLE;
         r_settleCnt <= '0;
      end else begin
         r_state     <= w_nextState;
         r_settleCnt <= w_settleCntNext;
      end
   end

   // Power-down outranks a change, which outranks normal sequencing; restart clears the wave.
   always_comb begin
      w_nextState     = r_state;
      w_settleCntNext = r_settleCnt;
      w_restart       = 1'b0;
      if (w_newScale == SCALE_PDOWN) begin
         w_nextState     = PDOWN;
         w_settleCntNext = '0;
         w_restart       = 1'b1;
      end else if (w_change) begin
         w_nextState     = SETTLE;
         w_settleCntNext = '0;
         w_restart       = 1'b1;
      end else begin
         case (r_state)
            SETTLE: begin
               if (r_settleCnt == SETTLE_LAST) begin
                  w_nextState     = RUN;
                  w_settleCntNext = '0;
                  w_restart       = 1'b1;
               end else begin
                  w_settleCntNext = r_settleCnt + CNT_W'(1);
               end
            end
            RUN: begin
               w_nextState = RUN;
            end
            default: begin
               w_nextState     = SETTLE;
               w_settleCntNext = '0;
               w_restart       = 1'b1;
            end
         endcase
      end
   end

   assign settling = (r_state != RUN);

   cs_wave_gen u_waveGen (
      .clk_1MHz  (clk_1MHz),
      .rst_n     (rst_n),
      .i_eff     (w_eff),
      .i_restart (w_restart),
      .i_enable  (r_state == RUN),
      .o_csOut   (cs_out),
      .o_edgeCnt (edge_cnt)
   );

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Directed bench for color_sensor_emulator; expected values queued in a scoreboard and popped on measurement.
`timescale 1ns/1ps
module tb_color_sensor_emulator;

   logic        clk_1MHz = 1'b0;
   logic        rst_n;
   logic [1:0]  filter;
   logic [1:0]  scale;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [15:0] cfg_data;
   logic        cs_out;
   logic        settling;
   logic [15:0] edge_cnt;

   typedef struct {
      string       tag;
      int unsigned value;
   } sbEntry_t;

   sbEntry_t sbQ[$];
   int       compared   = 0;
   int       mismatched = 0;
   int       modelHp [4];
   int       cycles;
   int       partA;

   color_sensor_emulator dut (
      .clk_1MHz (clk_1MHz),
      .rst_n    (rst_n),
      .filter   (filter),
      .scale    (scale),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .cs_out   (cs_out),
      .settling (settling),
      .edge_cnt (edge_cnt)
   );

   always #500 clk_1MHz = ~clk_1MHz;

   // Reference half-period in clock cycles for a channel value and scale code.
   function automatic int halfPeriod(input int hp, input logic [1:0] sc);
      case (sc)
         2'b01:   return hp * 50;
         2'b10:   return hp * 5;
         2'b11:   return hp;
         default: return 0;
      endcase
   endfunction

   task automatic pushExpect(input string tag, input int unsigned value);
      sbEntry_t e;
      e.tag   = tag;
      e.value = value;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input int unsigned observed);
      sbEntry_t e;
      compared++;
      if (sbQ.size() == 0) begin
         mismatched++;
         $error("[TB] FAIL scoreboard_empty: observed %0d, expected an entry", observed);
      end else begin
         e = sbQ.pop_front();
         assert (observed === e.value) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", e.tag, observed, e.value);
         end
      end
   endtask

   task automatic applyStimulus(input logic [1:0] f, input logic [1:0] s);
      filter = f;
      scale  = s;
   endtask

   task automatic cfgWrite(input logic [1:0] sel, input logic [15:0] data);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_data = data;
      modelHp[sel] = int'(data);
   endtask

   // Counts negedges until the chosen output reaches the wanted level, bounded by limit.
   task automatic waitFor(input bit useSettling, input bit want, input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk_1MHz);
         n++;
      end while ((((useSettling ? settling : cs_out)) !== want) && (n < limit));
   endtask

   task automatic checkImmediateClear(input string tag);
      pushExpect({tag, "_cs_out"}, 0);
      checkOutput(32'(cs_out));
      pushExpect({tag, "_settling"}, 1);
      checkOutput(32'(settling));
      pushExpect({tag, "_edge_cnt"}, 0);
      checkOutput(32'(edge_cnt));
   endtask

   initial begin
      modelHp[0] = 100;
      modelHp[3] = 80;
      modelHp[1] = 120;
      modelHp[2] = 40;
      rst_n    = 1'b0;
      cfg_we   = 1'b0;
      cfg_sel  = 2'b00;
      cfg_data = 16'd0;
      applyStimulus(2'b11, 2'b11);
      repeat (3) @(negedge clk_1MHz);

      $display("[TB] reset state and green at 100%%");
      checkImmediateClear("reset");
      rst_n = 1'b1;
      pushExpect("reset_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("green_first_rise", halfPeriod(modelHp[3], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);
      for (int i = 0; i < 2; i++) begin
         pushExpect("green_low_half", halfPeriod(modelHp[3], 2'b11));
         waitFor(0, 0, 500, cycles);
         checkOutput(cycles);
         pushExpect("green_high_half", halfPeriod(modelHp[3], 2'b11));
         waitFor(0, 1, 500, cycles);
         checkOutput(cycles);
      end
      pushExpect("green_edge_cnt3", 3);
      checkOutput(32'(edge_cnt));

      $display("[TB] red at 20%%");
      applyStimulus(2'b00, 2'b10);
      @(negedge clk_1MHz);
      checkImmediateClear("red20_change");
      pushExpect("red20_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("red20_first_rise", halfPeriod(modelHp[0], 2'b10));
      waitFor(0, 1, 2000, cycles);
      checkOutput(cycles);
      pushExpect("red20_edge_cnt1", 1);
      checkOutput(32'(edge_cnt));
      pushExpect("red20_low_half", halfPeriod(modelHp[0], 2'b10));
      waitFor(0, 0, 2000, cycles);
      checkOutput(cycles);
      pushExpect("red20_high_half", halfPeriod(modelHp[0], 2'b10));
      waitFor(0, 1, 2000, cycles);
      checkOutput(cycles);
      pushExpect("red20_edge_cnt2", 2);
      checkOutput(32'(edge_cnt));

      $display("[TB] filter switch green to blue while high");
      applyStimulus(2'b11, 2'b11);
      @(negedge clk_1MHz);
      pushExpect("green_again_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("green_again_rise", halfPeriod(modelHp[3], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);
      applyStimulus(2'b01, 2'b11);
      @(negedge clk_1MHz);
      checkImmediateClear("blue_change");
      pushExpect("blue_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("blue_first_rise", halfPeriod(modelHp[1], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);
      pushExpect("blue_low_half", halfPeriod(modelHp[1], 2'b11));
      waitFor(0, 0, 500, cycles);
      checkOutput(cycles);

      $display("[TB] green half-period write mid-phase");
      applyStimulus(2'b11, 2'b11);
      @(negedge clk_1MHz);
      pushExpect("green_wr_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("green_wr_rise", halfPeriod(modelHp[3], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);
      pushExpect("green_wr_current_half", halfPeriod(modelHp[3], 2'b11));
      repeat (30) @(negedge clk_1MHz);
      cfgWrite(2'b11, 16'd20);
      @(negedge clk_1MHz);
      cfg_we = 1'b0;
      waitFor(0, 0, 500, partA);
      checkOutput(30 + 1 + partA);
      pushExpect("green_wr_new_high", halfPeriod(modelHp[3], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);
      pushExpect("green_wr_new_low", halfPeriod(modelHp[3], 2'b11));
      waitFor(0, 0, 500, cycles);
      checkOutput(cycles);

      $display("[TB] red with zero half-period, then recovery");
      cfgWrite(2'b00, 16'd0);
      applyStimulus(2'b00, 2'b11);
      @(negedge clk_1MHz);
      cfg_we = 1'b0;
      checkImmediateClear("red0_change");
      pushExpect("red0_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("red0_no_rise_cycles", 10000);
      waitFor(0, 1, 10000, cycles);
      checkOutput(cycles);
      pushExpect("red0_cs_out", 0);
      checkOutput(32'(cs_out));
      pushExpect("red0_edge_cnt", 0);
      checkOutput(32'(edge_cnt));
      cfgWrite(2'b00, 16'd50);
      @(negedge clk_1MHz);
      cfg_we = 1'b0;
      pushExpect("red50_resumed", 1);
      waitFor(0, 1, 200, cycles);
      checkOutput(32'(cs_out));
      pushExpect("red50_low_half", halfPeriod(modelHp[0], 2'b11));
      waitFor(0, 0, 500, cycles);
      checkOutput(cycles);
      pushExpect("red50_high_half", halfPeriod(modelHp[0], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);
      pushExpect("red50_edge_cnt2", 2);
      checkOutput(32'(edge_cnt));

      $display("[TB] power-down and return");
      applyStimulus(2'b00, 2'b00);
      @(negedge clk_1MHz);
      checkImmediateClear("pdown_entry");
      pushExpect("pdown_no_rise_cycles", 100);
      waitFor(0, 1, 100, cycles);
      checkOutput(cycles);
      pushExpect("pdown_settling_held", 1);
      checkOutput(32'(settling));
      applyStimulus(2'b00, 2'b11);
      @(negedge clk_1MHz);
      pushExpect("pdown_exit_settling", 1);
      checkOutput(32'(settling));
      pushExpect("pdown_exit_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("pdown_exit_rise", halfPeriod(modelHp[0], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);

      $display("[TB] asynchronous reset mid-run");
      repeat (10) @(negedge clk_1MHz);
      #100;
      rst_n = 1'b0;
      #1;
      checkImmediateClear("async_reset");
      modelHp[0] = 100;
      modelHp[3] = 80;
      @(negedge clk_1MHz);
      rst_n = 1'b1;
      pushExpect("post_reset_settle_len", 10);
      waitFor(1, 0, 50, cycles);
      checkOutput(cycles);
      pushExpect("post_reset_red_default_rise", halfPeriod(modelHp[0], 2'b11));
      waitFor(0, 1, 500, cycles);
      checkOutput(cycles);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
